// File: rtl/fetch_buffer.sv
// Fetch buffer: pairs imem responses with request PCs and queues them for decode.
// FETCH_BUF_PERF_EN adds saturating drop_cnt and stall_cnt outputs.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_fire,
  input  logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            resp_ready,
  output logic            fetch_allow,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr,
`ifdef FETCH_BUF_PERF_EN
  output logic [15:0]     drop_cnt,
  output logic [15:0]     stall_cnt,
`endif
  input  logic            dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] in_mem [DEPTH];

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            drop_q, drop_d;

  logic resp_ok, full, push, pop, discard;
  logic [CW-1:0] occ;

  assign resp_ok = resp_valid & pend_q;
  assign full    = (count_q == CW'(DEPTH));
  assign push    = resp_ok & ~drop_q & ~flush & ~full;
  assign pop     = dec_valid & dec_ready & ~flush;
  assign discard = resp_ok & (drop_q | flush);

  assign resp_ready  = 1'b1;
  assign occ         = count_q + CW'(pend_q);
  assign fetch_allow = (occ < CW'(DEPTH));
  assign dec_valid   = (count_q != '0);
  assign dec_pc      = dec_valid ? pc_mem[rd_q] : '0;
  assign dec_instr   = dec_valid ? in_mem[rd_q] : '0;

  always_comb begin
    count_d   = count_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q & ~resp_ok;
    if (resp_ok)
      pend_d = 1'b0;
    if (req_fire) begin
      pend_d    = 1'b1;
      pend_pc_d = req_addr;
    end
    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      // whatever is still outstanding after this edge is stale
      drop_d  = drop_d | req_fire | (pend_q & ~resp_valid);
    end else begin
      if (push)
        wr_d = wr_q + AW'(1);
      if (pop)
        rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= pend_pc_q;
      in_mem[wr_q] <= resp_data;
    end
  end

`ifdef FETCH_BUF_PERF_EN
  logic [15:0] drop_cnt_q, stall_cnt_q;
  logic [15:0] drop_cnt_d, stall_cnt_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (discard && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (dec_valid && !dec_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: ordering, credit, flush/drop, wrap, reset.
// Build with FETCH_BUF_PERF_EN to also check the perf counters.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_fire;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        fetch_allow;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
`ifdef FETCH_BUF_PERF_EN
  logic [15:0] drop_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic tb_pend;
  logic [31:0] qpc[$];
  logic [31:0] qin[$];

  fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_fire   (req_fire),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .fetch_allow(fetch_allow),
    .dec_valid  (dec_valid),
    .dec_pc     (dec_pc),
    .dec_instr  (dec_instr),
`ifdef FETCH_BUF_PERF_EN
    .drop_cnt   (drop_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .dec_ready  (dec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    chk("req_allow", 32'(fetch_allow), 32'd1);
    req_fire = 1'b1;
    req_addr = a;
    tick();
    req_fire = 1'b0;
    tb_pend  = 1'b1;
  endtask

  task automatic resp(input logic [31:0] d);
    chk("resp_pend", 32'(tb_pend), 32'd1);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
    tb_pend    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    tb_pend = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    req_fire = 1'b0; req_addr = '0;
    resp_valid = 1'b0; resp_data = '0;
    dec_ready = 1'b0; tb_pend = 1'b0;
    #2;
    do_reset();
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_allow", 32'(fetch_allow), 32'd1);
    chk("rst_rready", 32'(resp_ready), 32'd1);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
`ifdef FETCH_BUF_PERF_EN
    chk("rst_dropcnt", 32'(drop_cnt), 32'd0);
    chk("rst_stallcnt", 32'(stall_cnt), 32'd0);
`endif

    // 1: ordering and latency
    dec_ready = 1'b1;
    req(32'h0);
    chk("t1_lat0", 32'(dec_valid), 32'd0);
    resp(32'h0000_0013);
    chk("t1_v0", 32'(dec_valid), 32'd1);
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_in0", dec_instr, 32'h0000_0013);
    req(32'h4);
    chk("t1_empty0", 32'(dec_valid), 32'd0);
    resp(32'h0010_0093);
    chk("t1_v1", 32'(dec_valid), 32'd1);
    chk("t1_pc1", dec_pc, 32'h4);
    chk("t1_in1", dec_instr, 32'h0010_0093);
    tick();
    chk("t1_empty1", 32'(dec_valid), 32'd0);

    // 2: fill and credit
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(32'(4 * i));
      chk("t2_allow_req", 32'(fetch_allow), 32'(i + 1 < 4));
      resp(32'h1000_0000 + 32'(i));
      chk("t2_allow_rsp", 32'(fetch_allow), 32'(i + 1 < 4));
    end
    chk("t2_head_pc", dec_pc, 32'h0);
    chk("t2_head_in", dec_instr, 32'h1000_0000);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t2_allow_pop", 32'(fetch_allow), 32'd1);
    chk("t2_head2_pc", dec_pc, 32'h4);
    dec_ready = 1'b1;
    tick(); tick(); tick();
    chk("t2_drained", 32'(dec_valid), 32'd0);

    // 3: flush with an outstanding request
    dec_ready = 1'b0;
    req(32'h0); resp(32'hA000_0000);
    req(32'h4); resp(32'hA000_0004);
    req(32'h8);
    chk("t3_pre_valid", 32'(dec_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_post_valid", 32'(dec_valid), 32'd0);
    chk("t3_post_allow", 32'(fetch_allow), 32'd1);
    tick();
    resp(32'hDEAD_BEEF);
    chk("t3_stale", 32'(dec_valid), 32'd0);
    req(32'h100);
    resp(32'h0000_0073);
    chk("t3_v", 32'(dec_valid), 32'd1);
    chk("t3_pc", dec_pc, 32'h100);
    chk("t3_in", dec_instr, 32'h0000_0073);
`ifdef FETCH_BUF_PERF_EN
    chk("t3_dropcnt", 32'(drop_cnt), 32'd1);
`endif
    dec_ready = 1'b1;
    tick();
    chk("t3_empty", 32'(dec_valid), 32'd0);

    // 4: flush coincident with response and req_fire
    req(32'h4);
    resp_valid = 1'b1; resp_data = 32'h0000_4444;
    req_fire = 1'b1; req_addr = 32'h8;
    flush = 1'b1;
    tick();
    resp_valid = 1'b0; req_fire = 1'b0; flush = 1'b0;
    tb_pend = 1'b1;
    chk("t4_no4", 32'(dec_valid), 32'd0);
    resp(32'h0000_8888);
    chk("t4_no8", 32'(dec_valid), 32'd0);
    req(32'hC);
    resp(32'h0000_CCCC);
    chk("t4_v", 32'(dec_valid), 32'd1);
    chk("t4_pc", dec_pc, 32'hC);
    chk("t4_in", dec_instr, 32'h0000_CCCC);
`ifdef FETCH_BUF_PERF_EN
    chk("t4_dropcnt", 32'(drop_cnt), 32'd3);
`endif
    tick();
    chk("t4_empty", 32'(dec_valid), 32'd0);

    // 5: simultaneous push/pop near full, across pointer wrap
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(32'h200 + 32'(4 * i));
      resp(32'h5000_0000 + 32'(i));
      qpc.push_back(32'h200 + 32'(4 * i));
      qin.push_back(32'h5000_0000 + 32'(i));
    end
    for (int k = 3; k < 10; k++) begin
      req(32'h200 + 32'(4 * k));
      if (k == 3)
        chk("t5_allow_full", 32'(fetch_allow), 32'd0);
      dec_ready = 1'b1;
      resp(32'h5000_0000 + 32'(k));
      dec_ready = 1'b0;
      void'(qpc.pop_front());
      void'(qin.pop_front());
      qpc.push_back(32'h200 + 32'(4 * k));
      qin.push_back(32'h5000_0000 + 32'(k));
      chk("t5_allow", 32'(fetch_allow), 32'd1);
      chk("t5_pc", dec_pc, qpc[0]);
      chk("t5_in", dec_instr, qin[0]);
    end
    dec_ready = 1'b1;
    while (qpc.size() > 0) begin
      chk("t5_drain_pc", dec_pc, qpc[0]);
      chk("t5_drain_in", dec_instr, qin[0]);
      tick();
      void'(qpc.pop_front());
      void'(qin.pop_front());
    end
    chk("t5_empty", 32'(dec_valid), 32'd0);

    // 6: reset mid-stream (entries buffered, then drop pending)
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(32'h300 + 32'(4 * i));
      resp(32'h6000_0000 + 32'(i));
    end
    req(32'h50);
    do_reset();
    chk("t6_valid", 32'(dec_valid), 32'd0);
    chk("t6_allow", 32'(fetch_allow), 32'd1);
    chk("t6_pc", dec_pc, 32'd0);
    req(32'h60);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_reset();
    chk("t6_valid2", 32'(dec_valid), 32'd0);
    req(32'h70);
    resp(32'h0000_7777);
    chk("t6_v", 32'(dec_valid), 32'd1);
    chk("t6_pc2", dec_pc, 32'h70);
    chk("t6_in2", dec_instr, 32'h0000_7777);
`ifdef FETCH_BUF_PERF_EN
    chk("t6_dropcnt", 32'(drop_cnt), 32'd0);
    chk("t6_stall0", 32'(stall_cnt), 32'd0);
    tick(); tick();
    chk("t6_stall2", 32'(stall_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
